bcd_updown_cntr: RTL and testbench

- Parametrised, cascadable multi-digit modulo counter; successor to the single-decade synchronous counter.
- Adds per-digit modulus, up/down counting, synchronous clear, parallel load with digit validation, and a registered wrap pulse.
- Used for decimal event and time counting.
- Instances cascade by feeding carry_out into the next instance's cnt_en.

---
 rtl/bcd_cntr_pkg.sv | 30 +++
 rtl/bcd_digit_cell.sv | 66 ++++++
 rtl/bcd_updown_cntr.sv | 137 +++++++++++++
 tb/tb_bcd_updown_cntr.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_cntr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_cntr_pkg
//  Description : Shared constants, operation encoding and digit range check
//                for the cascadable multi-digit up/down modulo counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_cntr_pkg;

  // Width of one counter digit.
  localparam int DIGIT_W = 4;

  // Operation selected on a clock edge, listed from highest priority down.
  typedef enum logic [1:0] {
    OP_CLR   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2,
    OP_HOLD  = 2'd3
  } cntr_op_e;

  // A loaded digit is accepted only if it does not exceed the terminal value.
  function automatic logic digit_valid(
    input logic [DIGIT_W-1:0] value,
    input logic [DIGIT_W-1:0] max
  );
    return (value <= max);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_cell
//  Description : One 4-bit counter digit with clear, validated load and an
//                up/down step. Reports when it sits at its terminal value or
//                at zero so the parent can build the carry/borrow chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_cell
  import bcd_cntr_pkg::*;
#(
  parameter int DIGIT_MAX = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               step,
  input  logic               up_dn,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_max,
  output logic               at_zero
);

  localparam logic [DIGIT_W-1:0] C_DIGIT_MAX = DIGIT_W'(DIGIT_MAX);
  localparam logic [DIGIT_W-1:0] C_ONE       = DIGIT_W'(1);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  // Terminal-value and zero flags feed the parent's carry/borrow chain.
  always_comb begin
    at_max  = (digit_q == C_DIGIT_MAX);
    at_zero = (digit_q == '0);
  end

  // Next digit value: clear wins, then load (out-of-range forced to 0), then step.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = digit_valid(load_digit, C_DIGIT_MAX) ? load_digit : '0;
    end else if (step) begin
      if (up_dn) begin
        digit_d = at_max ? '0 : (digit_q + C_ONE);
      end else begin
        digit_d = at_zero ? C_DIGIT_MAX : (digit_q - C_ONE);
      end
    end
  end

  // Digit storage with asynchronous reset to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule
`default_nettype wire

// File: rtl/bcd_updown_cntr.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_updown_cntr
//  Description : Parametrised, cascadable multi-digit modulo up/down counter
//                with synchronous clear, validated parallel load, a
//                combinational terminal-count output and a registered wrap
//                pulse. Chain instances by driving the next cnt_en from
//                carry_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_updown_cntr
  import bcd_cntr_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int DIGIT_MAX  = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  input  logic                          cnt_en,
  input  logic                          up_dn,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count,
  output logic                          carry_out,
  output logic                          wrap,
  output logic                          load_err
);

  localparam logic [DIGIT_W-1:0] C_DIGIT_MAX = DIGIT_W'(DIGIT_MAX);

  cntr_op_e              w_op;
  logic [NUM_DIGITS-1:0] w_step;
  logic [NUM_DIGITS-1:0] w_at_max;
  logic [NUM_DIGITS-1:0] w_at_zero;
  logic                  w_load_bad;

  logic wrap_q;
  logic wrap_d;
  logic load_err_q;
  logic load_err_d;

  // Resolve the edge operation: clear over load over count over hold.
  always_comb begin
    if (clr) begin
      w_op = OP_CLR;
    end else if (load) begin
      w_op = OP_LOAD;
    end else if (cnt_en) begin
      w_op = OP_COUNT;
    end else begin
      w_op = OP_HOLD;
    end
  end

  // Step chain: digit k steps when counting and every lower digit is at its
  // turnover value (terminal value going up, zero going down).
  always_comb begin
    logic run;
    run    = (w_op == OP_COUNT);
    w_step = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_step[k] = run;
      run       = run & (up_dn ? w_at_max[k] : w_at_zero[k]);
    end
  end

  // Flag any load digit that exceeds the terminal value.
  always_comb begin
    w_load_bad = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!digit_valid(load_val[k*DIGIT_W +: DIGIT_W], C_DIGIT_MAX)) begin
        w_load_bad = 1'b1;
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      bcd_digit_cell #(
        .DIGIT_MAX (DIGIT_MAX)
      ) u_cell (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_op == OP_CLR),
        .load       (w_op == OP_LOAD),
        .load_digit (load_val[k*DIGIT_W +: DIGIT_W]),
        .step       (w_step[k]),
        .up_dn      (up_dn),
        .digit      (count[k*DIGIT_W +: DIGIT_W]),
        .at_max     (w_at_max[k]),
        .at_zero    (w_at_zero[k])
      );
    end
  endgenerate

  // Terminal count is combinational so a cascaded stage steps on the same edge.
  always_comb begin
    carry_out = cnt_en & (up_dn ? (&w_at_max) : (&w_at_zero));
  end

  // Next wrap pulse and sticky load error; clear and load suppress the wrap.
  always_comb begin
    wrap_d     = 1'b0;
    load_err_d = load_err_q;
    case (w_op)
      OP_CLR: begin
        load_err_d = 1'b0;
      end
      OP_LOAD: begin
        load_err_d = load_err_q | w_load_bad;
      end
      OP_COUNT: begin
        wrap_d = carry_out;
      end
      default: begin
        wrap_d = 1'b0;
      end
    endcase
  end

  // Status registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_cntr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_updown_cntr
//  Description : Self-checking bench for bcd_updown_cntr: vector table,
//                reset corner cases, randomised run against an arithmetic
//                reference model, and a base-6 cascaded pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_cntr;

  localparam int ND = 3;
  localparam int DM = 9;
  localparam int W  = 4 * ND;
  localparam int MODV = 1000;

  localparam int PND = 2;
  localparam int PDM = 5;
  localparam int PW  = 4 * PND;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          load;
  logic [W-1:0]  load_val;
  logic          cnt_en;
  logic          up_dn;
  logic [W-1:0]  count;
  logic          carry_out;
  logic          wrap;
  logic          load_err;

  logic          p_clr;
  logic          p_load;
  logic [PW-1:0] p_lv_lo;
  logic [PW-1:0] p_lv_hi;
  logic          p_en;
  logic          p_ud;
  logic [PW-1:0] lo_count;
  logic [PW-1:0] hi_count;
  logic          lo_carry;
  logic          hi_carry;
  logic          lo_wrap;
  logic          hi_wrap;
  logic          lo_err;
  logic          hi_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_updown_cntr #(.NUM_DIGITS(ND), .DIGIT_MAX(DM)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .cnt_en(cnt_en), .up_dn(up_dn), .count(count), .carry_out(carry_out),
    .wrap(wrap), .load_err(load_err)
  );

  bcd_updown_cntr #(.NUM_DIGITS(PND), .DIGIT_MAX(PDM)) u_lo (
    .clk(clk), .rst(rst), .clr(p_clr), .load(p_load), .load_val(p_lv_lo),
    .cnt_en(p_en), .up_dn(p_ud), .count(lo_count), .carry_out(lo_carry),
    .wrap(lo_wrap), .load_err(lo_err)
  );

  bcd_updown_cntr #(.NUM_DIGITS(PND), .DIGIT_MAX(PDM)) u_hi (
    .clk(clk), .rst(rst), .clr(p_clr), .load(p_load), .load_val(p_lv_hi),
    .cnt_en(lo_carry), .up_dn(p_ud), .count(hi_count), .carry_out(hi_carry),
    .wrap(hi_wrap), .load_err(hi_err)
  );

  typedef struct {
    bit          c;
    bit          l;
    logic [11:0] lv;
    bit          e;
    bit          u;
    logic [11:0] exp_cnt;
    bit          exp_carry;
    bit          exp_wrap;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit c, bit l, logic [11:0] lv, bit e, bit u,
                              logic [11:0] ec, bit ecar, bit ew, bit ee);
    vec_t v;
    v.c = c; v.l = l; v.lv = lv; v.e = e; v.u = u;
    v.exp_cnt = ec; v.exp_carry = ecar; v.exp_wrap = ew; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Integer value -> packed digits in the given base.
  function automatic logic [31:0] to_digits(input int v, input int nd, input int base);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(v % base);
      v = v / base;
    end
    return r;
  endfunction

  // Packed load word -> integer value, out-of-range digits become 0.
  function automatic int load_model(input logic [31:0] lv, input int nd, input int dmax,
                                    output bit bad);
    int value, mult, d;
    value = 0; mult = 1; bad = 1'b0;
    for (int k = 0; k < nd; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > dmax) begin
        d   = 0;
        bad = 1'b1;
      end
      value = value + d * mult;
      mult  = mult * (dmax + 1);
    end
    return value;
  endfunction

  task automatic drive(input bit c, input bit l, input logic [W-1:0] lv, input bit e, input bit u);
    clr = c; load = l; load_val = lv; cnt_en = e; up_dn = u;
  endtask

  initial begin
    int   mval;
    bit   merr;
    bit   exp_carry;
    bit   exp_wrap;
    bit   bad;
    int   wraps;
    logic [W-1:0] lv;

    rst = 1'b1;
    drive(0, 0, '0, 0, 1);
    p_clr = 0; p_load = 0; p_lv_lo = '0; p_lv_hi = '0; p_en = 0; p_ud = 1;

    // Reset held for three cycles, then released.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_err", 32'(load_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_count", 32'(count), 0);

    // Table of directed vectors.
    vecs.push_back(mk(0,1,12'h097,0,1, 12'h097,0,0,0));
    vecs.push_back(mk(0,0,12'h000,1,1, 12'h098,0,0,0));
    vecs.push_back(mk(0,0,12'h000,1,1, 12'h099,0,0,0));
    vecs.push_back(mk(0,0,12'h000,1,1, 12'h100,0,0,0));
    vecs.push_back(mk(0,0,12'h000,1,1, 12'h101,0,0,0));
    vecs.push_back(mk(0,1,12'h998,0,1, 12'h998,0,0,0));
    vecs.push_back(mk(0,0,12'h000,1,1, 12'h999,0,0,0));
    vecs.push_back(mk(0,0,12'h000,1,1, 12'h000,1,1,0));
    vecs.push_back(mk(0,0,12'h000,0,1, 12'h000,0,0,0));
    vecs.push_back(mk(0,1,12'h001,0,0, 12'h001,0,0,0));
    vecs.push_back(mk(0,0,12'h000,1,0, 12'h000,0,0,0));
    vecs.push_back(mk(0,0,12'h000,1,0, 12'h999,1,1,0));
    vecs.push_back(mk(0,1,12'h100,1,1, 12'h100,1,0,0));
    vecs.push_back(mk(0,0,12'h000,1,0, 12'h099,0,0,0));
    vecs.push_back(mk(0,1,12'h555,0,1, 12'h555,0,0,0));
    vecs.push_back(mk(1,1,12'h321,1,1, 12'h000,0,0,0));
    vecs.push_back(mk(0,1,12'h321,1,1, 12'h321,0,0,0));
    vecs.push_back(mk(0,1,12'h3A7,0,1, 12'h307,0,0,1));
    vecs.push_back(mk(0,0,12'h000,1,1, 12'h308,0,0,1));
    vecs.push_back(mk(0,0,12'h000,1,1, 12'h309,0,0,1));
    vecs.push_back(mk(0,0,12'h000,1,1, 12'h310,0,0,1));
    vecs.push_back(mk(0,0,12'h000,1,1, 12'h311,0,0,1));
    vecs.push_back(mk(0,0,12'h000,1,1, 12'h312,0,0,1));
    vecs.push_back(mk(1,0,12'h000,0,1, 12'h000,0,0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].c, vecs[i].l, vecs[i].lv, vecs[i].e, vecs[i].u);
      #1;
      chk($sformatf("vec%0d_carry", i), 32'(carry_out), 32'(vecs[i].exp_carry));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
      chk($sformatf("vec%0d_err", i), 32'(load_err), 32'(vecs[i].exp_err));
    end

    // Asynchronous reset mid-cycle while holding 457.
    @(negedge clk);
    drive(0, 1, 12'h457, 0, 1);
    @(posedge clk);
    #1;
    chk("pre_async_count", 32'(count), 32'h457);
    @(negedge clk);
    drive(0, 0, '0, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_count", 32'(count), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    drive(0, 0, '0, 1, 1);
    @(posedge clk);
    #1;
    chk("post_async_count", 32'(count), 1);

    // Randomised run against the arithmetic model, starting from a clear.
    @(negedge clk);
    drive(1, 0, '0, 0, 1);
    @(posedge clk);
    #1;
    mval = 0;
    merr = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
        case ($urandom_range(0, 5))
          0:       lv[4*k +: 4] = 4'($urandom_range(0, 15));
          1:       lv[4*k +: 4] = 4'(DM);
          2:       lv[4*k +: 4] = 4'(0);
          default: lv[4*k +: 4] = 4'($urandom_range(0, DM));
        endcase
      end
      drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0), lv,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
      exp_carry = cnt_en && (up_dn ? (mval == MODV - 1) : (mval == 0));
      #1;
      chk($sformatf("rnd%0d_carry", n), 32'(carry_out), 32'(exp_carry));
      if (clr) begin
        mval = 0; merr = 1'b0; exp_wrap = 1'b0;
      end else if (load) begin
        mval = load_model(32'(load_val), ND, DM, bad);
        merr = merr | bad;
        exp_wrap = 1'b0;
      end else if (cnt_en) begin
        exp_wrap = exp_carry;
        mval = up_dn ? (mval + 1) % MODV : (mval + MODV - 1) % MODV;
      end else begin
        exp_wrap = 1'b0;
      end
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_count", n), 32'(count), to_digits(mval, ND, DM + 1));
      chk($sformatf("rnd%0d_wrap", n), 32'(wrap), 32'(exp_wrap));
      chk($sformatf("rnd%0d_err", n), 32'(load_err), 32'(merr));
    end
    @(negedge clk);
    drive(0, 0, '0, 0, 1);

    // Base-6 two-digit sweep with a cascaded upper stage.
    @(negedge clk);
    p_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("pair_clr_lo", 32'(lo_count), 0);
    chk("pair_clr_hi", 32'(hi_count), 0);
    @(negedge clk);
    p_clr = 1'b0;
    p_en  = 1'b1;
    p_ud  = 1'b1;
    wraps = 0;
    for (int i = 0; i < 36; i++) begin
      @(posedge clk);
      #1;
      if (lo_wrap) wraps++;
      chk($sformatf("sweep%0d_lo", i), 32'(lo_count), to_digits((i + 1) % 36, PND, PDM + 1));
      chk($sformatf("sweep%0d_hi", i), 32'(hi_count), to_digits((i + 1) / 36, PND, PDM + 1));
    end
    chk("sweep_wrap_at_end", 32'(lo_wrap), 1);
    chk("sweep_wrap_count", 32'(wraps), 1);
    @(posedge clk);
    #1;
    chk("sweep_wrap_single", 32'(lo_wrap), 0);
    chk("sweep_hi_carry", 32'(hi_carry), 0);

    @(negedge clk);
    p_en    = 1'b0;
    p_load  = 1'b1;
    p_lv_lo = 8'h55;
    p_lv_hi = 8'h05;
    @(posedge clk);
    #1;
    chk("casc_load_lo", 32'(lo_count), 32'h55);
    chk("casc_load_hi", 32'(hi_count), 32'h05);
    @(negedge clk);
    p_load = 1'b0;
    p_en   = 1'b1;
    #1;
    chk("casc_lo_carry", 32'(lo_carry), 1);
    @(posedge clk);
    #1;
    chk("casc_lo", 32'(lo_count), 32'h00);
    chk("casc_hi", 32'(hi_count), 32'h10);
    chk("casc_lo_wrap", 32'(lo_wrap), 1);
    chk("casc_hi_wrap", 32'(hi_wrap), 0);
    chk("casc_errs", 32'({lo_err, hi_err}), 0);
    @(negedge clk);
    p_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
